// File: rtl/compound_type_sender.sv
// Transmit side of the blocking CompoundType interface: buffers integer payloads
// in a small FIFO and emits them as CompoundType messages with alternating mode.
package compound_type_pkg;
    typedef enum logic {
        MODE_READ  = 1'b0,
        MODE_WRITE = 1'b1
    } mode_t;

    typedef struct packed {
        mode_t              mode;
        logic signed [31:0] x;
        logic               y;
    } compound_type_t;
endpackage

// state     | meaning
// ----------+-------------------------------------------
// SECTION_A | next message goes out with mode = read
// SECTION_B | next message goes out with mode = write
module compound_type_sender
    import compound_type_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [31:0]  m_in,
    input  logic                m_in_sync,
    output logic                m_in_notify,
    output compound_type_t      b_out,
    input  logic                b_out_sync,
    output logic                b_out_notify,
    output logic [CNT_W-1:0]    sent_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(DEPTH);

    typedef enum logic {
        SECTION_A = 1'b0,
        SECTION_B = 1'b1
    } section_t;

    section_t         section_signal;
    section_t         section_next;
    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ;
    logic             push;
    logic             pop;

    // Both notifies come from registered occupancy only, so a pop never
    // frees a slot for a push in the same cycle.
    assign m_in_notify  = (occ < FULL_OCC);
    assign b_out_notify = (occ != '0);
    assign push         = m_in_notify & m_in_sync;
    assign pop          = b_out_notify & b_out_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            section_signal <= SECTION_A;
        end else begin
            section_signal <= section_next;
        end
    end

    always_comb begin
        section_next = section_signal;
        if (pop) begin
            section_next = (section_signal == SECTION_A) ? SECTION_B : SECTION_A;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            sent_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                sent_count <= sent_count + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= m_in;
        end
    end

    always_comb begin
        b_out.mode = MODE_READ;
        b_out.x    = '0;
        b_out.y    = 1'b0;
        if (b_out_notify) begin
            b_out.x    = mem[rd_ptr];
            b_out.y    = mem[rd_ptr][31];
            b_out.mode = (section_signal == SECTION_B) ? MODE_WRITE : MODE_READ;
        end
    end

endmodule

// File: tb/tb_compound_type_sender.sv
// Randomized self-checking bench for compound_type_sender against a queue-based
// model of the FIFO, the alternating mode and the delivered-message counter.
module tb_compound_type_sender;
    import compound_type_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic               clk;
    logic               rst;
    logic signed [31:0] m_in;
    logic               m_in_sync;
    logic               m_in_notify;
    compound_type_t     b_out;
    logic               b_out_sync;
    logic               b_out_notify;
    logic [CNT_W-1:0]   sent_count;

    int checks = 0;
    int errors = 0;

    int             mq[$];
    bit             msect;
    int             mcnt;
    compound_type_t obs_q[$];
    compound_type_t exp_q[$];

    compound_type_sender #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .m_in(m_in), .m_in_sync(m_in_sync),
        .m_in_notify(m_in_notify), .b_out(b_out), .b_out_sync(b_out_sync),
        .b_out_notify(b_out_notify), .sent_count(sent_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic compound_type_t mk(input mode_t m, input int v);
        compound_type_t r;
        r.mode = m;
        r.x    = v;
        r.y    = (v < 0);
        return r;
    endfunction

    function automatic compound_type_t exp_out();
        if (mq.size() == 0) return mk(MODE_READ, 0);
        return mk(msect ? MODE_WRITE : MODE_READ, mq[0]);
    endfunction

    function automatic void model_clear();
        mq.delete();
        msect = 1'b0;
        mcnt  = 0;
        obs_q.delete();
        exp_q.delete();
    endfunction

    // One clock: apply inputs, record any delivered message, advance the model.
    task automatic cycle(input int val, input logic in_sync, input logic out_sync);
        bit do_push, do_pop;
        m_in       = val;
        m_in_sync  = in_sync;
        b_out_sync = out_sync;
        do_push = in_sync && (mq.size() < DEPTH);
        do_pop  = out_sync && (mq.size() > 0);
        if (b_out_notify && out_sync) obs_q.push_back(b_out);
        @(posedge clk);
        if (do_pop) begin
            exp_q.push_back(exp_out());
            void'(mq.pop_front());
            msect = ~msect;
            mcnt  = (mcnt + 1) % (1 << CNT_W);
        end
        if (do_push) mq.push_back(val);
        #1;
        m_in_sync  = 1'b0;
        b_out_sync = 1'b0;
    endtask

    task automatic do_reset();
        m_in_sync  = 1'b0;
        b_out_sync = 1'b0;
        m_in       = 0;
        rst        = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (m_in_notify !== 1'b1) begin errors++; $display("FAIL reset_in_notify got %b want 1", m_in_notify); end
        checks++;
        if (b_out_notify !== 1'b0) begin errors++; $display("FAIL reset_out_notify got %b want 0", b_out_notify); end
        checks++;
        if (b_out !== mk(MODE_READ, 0)) begin errors++; $display("FAIL reset_b_out got %h want %h", b_out, mk(MODE_READ, 0)); end
        checks++;
        if (sent_count !== '0) begin errors++; $display("FAIL reset_sent_count got %0d want 0", sent_count); end
    endtask

    task automatic test_single();
        do_reset();
        cycle(5, 1'b1, 1'b0);
        checks++;
        if (b_out !== mk(MODE_READ, 5) || b_out_notify !== 1'b1) begin
            errors++; $display("FAIL single_visible got %h/%b want %h/1", b_out, b_out_notify, mk(MODE_READ, 5));
        end
        cycle(0, 1'b0, 1'b1);
        checks++;
        if (sent_count !== 8'd1 || b_out_notify !== 1'b0) begin
            errors++; $display("FAIL single_pop got cnt=%0d notify=%b want cnt=1 notify=0", sent_count, b_out_notify);
        end
        cycle(6, 1'b1, 1'b0);
        checks++;
        if (b_out !== mk(MODE_WRITE, 6)) begin errors++; $display("FAIL single_section_b got %h want %h", b_out, mk(MODE_WRITE, 6)); end
    endtask

    task automatic test_alternating();
        compound_type_t want[3];
        int vals[3];
        vals[0] = -3; vals[1] = 7; vals[2] = 0;
        want[0] = mk(MODE_READ, -3);
        want[1] = mk(MODE_WRITE, 7);
        want[2] = mk(MODE_READ, 0);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(vals[i], 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(0, 1'b0, 1'b1);
        checks++;
        if (obs_q.size() != 3) begin
            errors++; $display("FAIL alt_count got %0d messages want 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_q[i] !== want[i]) begin errors++; $display("FAIL alt_msg%0d got %h want %h", i, obs_q[i], want[i]); end
            end
        end
    endtask

    task automatic test_fill();
        int want[5];
        want[0] = 1; want[1] = 2; want[2] = 3; want[3] = 4; want[4] = 9;
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(i, 1'b1, 1'b0);
        checks++;
        if (m_in_notify !== 1'b0) begin errors++; $display("FAIL fill_full_notify got %b want 0", m_in_notify); end
        cycle(9, 1'b1, 1'b0);
        checks++;
        if (m_in_notify !== 1'b0 || b_out.x !== 1) begin
            errors++; $display("FAIL fill_hold got notify=%b head=%0d want notify=0 head=1", m_in_notify, b_out.x);
        end
        cycle(9, 1'b1, 1'b1);
        checks++;
        if (m_in_notify !== 1'b1 || b_out.x !== 2) begin
            errors++; $display("FAIL fill_no_bypass got notify=%b head=%0d want notify=1 head=2", m_in_notify, b_out.x);
        end
        cycle(9, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(0, 1'b0, 1'b1);
        checks++;
        if (obs_q.size() != 5) begin
            errors++; $display("FAIL fill_count got %0d messages want 5", obs_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs_q[i].x !== want[i]) begin errors++; $display("FAIL fill_order%0d got %0d want %0d", i, obs_q[i].x, want[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        cycle(10, 1'b1, 1'b0);
        cycle(11, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            base = mcnt;
            cycle(int'($urandom), 1'b1, 1'b1);
            checks++;
            if (b_out_notify !== 1'b1 || m_in_notify !== 1'b1 || mq.size() != 2) begin
                errors++; $display("FAIL b2b_occ got out=%b in=%b want out=1 in=1", b_out_notify, m_in_notify);
            end
            checks++;
            if (b_out !== exp_out()) begin errors++; $display("FAIL b2b_head got %h want %h", b_out, exp_out()); end
            checks++;
            if (int'(sent_count) != (base + 1) % 256) begin
                errors++; $display("FAIL b2b_cnt got %0d want %0d", sent_count, (base + 1) % 256);
            end
        end
        for (int i = 0; i < 4; i++) cycle(0, 1'b0, 1'b1);
        checks++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != 22) begin
            errors++; $display("FAIL b2b_total got %0d want 22", obs_q.size());
        end else begin
            for (int i = 0; i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_msg%0d got %h want %h", i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_wrap();
        int delivered;
        int guard;
        do_reset();
        delivered = 0;
        guard = 0;
        while (delivered < 256 && guard < 1000) begin
            if (mq.size() > 0) delivered++;
            cycle(int'($urandom), 1'b1, 1'b1);
            guard++;
        end
        checks++;
        if (delivered != 256) begin errors++; $display("FAIL wrap_budget got %0d delivered want 256", delivered); end
        checks++;
        if (sent_count !== '0) begin errors++; $display("FAIL wrap_count got %0d want 0", sent_count); end
        checks++;
        if (b_out !== exp_out() || b_out.mode !== MODE_READ) begin
            errors++; $display("FAIL wrap_section got %h want %h", b_out, exp_out());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(21, 1'b1, 1'b0);
        cycle(22, 1'b1, 1'b1);
        cycle(23, 1'b1, 1'b0);
        cycle(24, 1'b1, 1'b0);
        checks++;
        if (b_out !== mk(MODE_WRITE, 22) || mq.size() != 3) begin
            errors++; $display("FAIL areset_setup got %h want %h", b_out, mk(MODE_WRITE, 22));
        end
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        checks++;
        if (b_out_notify !== 1'b0 || m_in_notify !== 1'b1 || sent_count !== '0 || b_out !== mk(MODE_READ, 0)) begin
            errors++; $display("FAIL areset_immediate got out=%b in=%b cnt=%0d b=%h want 0/1/0/%h",
                               b_out_notify, m_in_notify, sent_count, b_out, mk(MODE_READ, 0));
        end
        @(negedge clk);
        rst = 1'b1;
        cycle(42, 1'b1, 1'b0);
        checks++;
        if (b_out !== mk(MODE_READ, 42)) begin errors++; $display("FAIL areset_after got %h want %h", b_out, mk(MODE_READ, 42)); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycle(int'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
            checks++;
            if (b_out !== exp_out() || b_out_notify !== (mq.size() > 0) ||
                m_in_notify !== (mq.size() < DEPTH) || int'(sent_count) != mcnt) begin
                errors++; $display("FAIL rand_cycle%0d got b=%h out=%b in=%b cnt=%0d want b=%h occ=%0d cnt=%0d",
                                   i, b_out, b_out_notify, m_in_notify, sent_count, exp_out(), mq.size(), mcnt);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_total got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_msg%0d got %h want %h", i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        m_in       = 0;
        m_in_sync  = 1'b0;
        b_out_sync = 1'b0;
        test_reset();
        test_single();
        test_alternating();
        test_fill();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
